// File: rtl/hit_pulse_gen_if.sv
// Bundled control, configuration and status signals of the hit-pulse generator.
// The master drives start/abort/config; the slave (generator) drives the pulse outputs.
interface hit_pulse_gen_if #(
  parameter int CNT_W = 16
);
  logic             iStart;
  logic [CNT_W-1:0] iHighCycles;
  logic [CNT_W-1:0] iLowCycles;
  logic [CNT_W-1:0] iNumPulses;
  logic             iAbort;
  logic             oHit;
  logic             oRiseMark;
  logic             oFallMark;
  logic             oBusy;
  logic             oDone;
  logic [CNT_W-1:0] oPulseCnt;

  modport master (
    output iStart, iHighCycles, iLowCycles, iNumPulses, iAbort,
    input  oHit, oRiseMark, oFallMark, oBusy, oDone, oPulseCnt
  );

  modport slave (
    input  iStart, iHighCycles, iLowCycles, iNumPulses, iAbort,
    output oHit, oRiseMark, oFallMark, oBusy, oDone, oPulseCnt
  );
endinterface

// File: rtl/hit_pulse_gen.sv
// Programmable hit-pulse train generator with rise/fall marker strobes.
// Every output is a register; the next-state logic computes their next values.
module hit_pulse_gen #(
  parameter int CNT_W = 16
) (
  input logic            iClk,
  input logic            iRst,
  hit_pulse_gen_if.slave bus
);

  typedef enum logic [1:0] {IDLE, HIGH, LOW, DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] h_q, h_d, l_q, l_d, n_q, n_d;
  logic [CNT_W-1:0] ph_q, ph_d, cnt_q, cnt_d;
  logic             hit_q, hit_d, rise_q, rise_d, fall_q, fall_d;
  logic             busy_q, busy_d, done_q, done_d;

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      state_q <= IDLE;
      h_q     <= '0;
      l_q     <= '0;
      n_q     <= '0;
      ph_q    <= '0;
      cnt_q   <= '0;
      hit_q   <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      l_q     <= l_d;
      n_q     <= n_d;
      ph_q    <= ph_d;
      cnt_q   <= cnt_d;
      hit_q   <= hit_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    l_d     = l_q;
    n_d     = n_q;
    ph_d    = ph_q;
    cnt_d   = cnt_q;
    hit_d   = hit_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        // Abort coinciding with start discards the start.
        if (bus.iStart && !bus.iAbort) begin
          cnt_d = '0;
          if (bus.iNumPulses != '0) begin
            h_d     = (bus.iHighCycles == '0) ? CNT_W'(1) : bus.iHighCycles;
            l_d     = (bus.iLowCycles == '0) ? CNT_W'(1) : bus.iLowCycles;
            n_d     = bus.iNumPulses;
            ph_d    = '0;
            cnt_d   = CNT_W'(1);
            state_d = HIGH;
            hit_d   = 1'b1;
            rise_d  = 1'b1;
            busy_d  = 1'b1;
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end
      HIGH: begin
        if (bus.iAbort) begin
          state_d = DONE;
          hit_d   = 1'b0;
          fall_d  = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else if (ph_q == h_q - CNT_W'(1)) begin
          state_d = LOW;
          hit_d   = 1'b0;
          fall_d  = 1'b1;
          ph_d    = '0;
        end else begin
          ph_d = ph_q + CNT_W'(1);
        end
      end
      LOW: begin
        if (bus.iAbort) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else if (ph_q == l_q - CNT_W'(1)) begin
          ph_d = '0;
          if (cnt_q < n_q) begin
            state_d = HIGH;
            hit_d   = 1'b1;
            rise_d  = 1'b1;
            cnt_d   = cnt_q + CNT_W'(1);
          end else begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end else begin
          ph_d = ph_q + CNT_W'(1);
        end
      end
      DONE: state_d = IDLE;
      default: begin
        state_d = IDLE;
        hit_d   = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign bus.oHit      = hit_q;
  assign bus.oRiseMark = rise_q;
  assign bus.oFallMark = fall_q;
  assign bus.oBusy     = busy_q;
  assign bus.oDone     = done_q;
  assign bus.oPulseCnt = cnt_q;

endmodule

// File: tb/tb_hit_pulse_gen.sv
// Bench for hit_pulse_gen: directed and random trains compared cycle by cycle
// against a waveform model derived from pulse period arithmetic.
module tb_hit_pulse_gen;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   passes = 0;
  int   last_cnt = 0;

  hit_pulse_gen_if #(.CNT_W(CW)) bus ();

  hit_pulse_gen #(.CNT_W(CW)) dut (
    .iClk (clk),
    .iRst (rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic hit, rise, fall, busy, done;
    int   cnt;
  } exp_t;

  // Expected outputs in cycle t after the start edge (t=1 is the first cycle).
  function automatic exp_t model(int h, int l, int n, int ta, int t);
    exp_t e;
    int hh, ll, per, total, d, u, o;
    e = '{default: 0};
    hh = (h == 0) ? 1 : h;
    ll = (l == 0) ? 1 : l;
    per = hh + ll;
    total = n * per;
    d = (n == 0) ? 1 : total + 1;
    if (n != 0 && ta > 0 && ta <= total) d = ta + 1;
    u = (t < d) ? t : d - 1;
    if (n != 0 && u >= 1) e.cnt = (u - 1) / per + 1;
    if (t < d) begin
      o = (t - 1) % per;
      e.hit  = (o < hh);
      e.rise = (o == 0);
      e.fall = (o == hh);
      e.busy = 1'b1;
    end else if (t == d) begin
      e.done = 1'b1;
      if (n != 0 && ta > 0 && d == ta + 1) e.fall = (((ta - 1) % per) < hh);
    end
    return e;
  endfunction

  task automatic chk(input string tag, input int t, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) passes++;
    else $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, t, got, exp);
  endtask

  task automatic chk_all(input string tag, input int t, input exp_t e);
    chk({tag, ".hit"}, t, 32'(bus.oHit), 32'(e.hit));
    chk({tag, ".rise"}, t, 32'(bus.oRiseMark), 32'(e.rise));
    chk({tag, ".fall"}, t, 32'(bus.oFallMark), 32'(e.fall));
    chk({tag, ".busy"}, t, 32'(bus.oBusy), 32'(e.busy));
    chk({tag, ".done"}, t, 32'(bus.oDone), 32'(e.done));
    chk({tag, ".cnt"}, t, 32'(bus.oPulseCnt), 32'(e.cnt));
  endtask

  // Start a train and check every cycle through a few idle cycles after oDone.
  task automatic run_train(input string tag, input int h, input int l, input int n,
                           input int ta, input bit noise);
    exp_t e;
    int hh, ll, limit;
    bit ended;
    hh = (h == 0) ? 1 : h;
    ll = (l == 0) ? 1 : l;
    limit = n * (hh + ll) + 4;
    ended = 1'b0;
    @(negedge clk);
    bus.iHighCycles = CW'(h);
    bus.iLowCycles  = CW'(l);
    bus.iNumPulses  = CW'(n);
    bus.iAbort      = 1'b0;
    bus.iStart      = 1'b1;
    @(posedge clk);
    for (int t = 1; t <= limit; t++) begin
      if (t > 1) @(posedge clk);
      #1;
      e = model(h, l, n, ta, t);
      chk_all(tag, t, e);
      last_cnt = e.cnt;
      if (e.done) ended = 1'b1;
      bus.iAbort = (t == ta);
      if (noise && !ended) begin
        bus.iStart      = 1'($urandom_range(0, 1));
        bus.iHighCycles = CW'($urandom);
        bus.iLowCycles  = CW'($urandom);
        bus.iNumPulses  = CW'($urandom);
      end else begin
        bus.iStart = 1'b0;
      end
    end
    bus.iAbort = 1'b0;
    bus.iStart = 1'b0;
  endtask

  initial begin
    exp_t idle_e;
    int h, l, n, ta, per;
    idle_e = '{default: 0};
    bus.iStart = 1'b0;
    bus.iAbort = 1'b0;
    bus.iHighCycles = '0;
    bus.iLowCycles = '0;
    bus.iNumPulses = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1 chk_all("reset", 0, idle_e);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk_all("post_reset", 0, idle_e);

    run_train("basic", 3, 2, 4, 0, 1'b0);
    run_train("n_zero", 4, 4, 0, 0, 1'b0);
    run_train("hl_zero", 0, 0, 2, 0, 1'b0);
    run_train("abort", 10, 10, 3, 24, 1'b0);
    run_train("abort_low", 2, 3, 3, 4, 1'b0);
    run_train("ignored", 2, 3, 3, 0, 1'b1);
    run_train("loop", 1, 1, 8, 0, 1'b0);
    run_train("max", 15, 15, 15, 0, 1'b0);

    // Abort together with start in IDLE discards the start
    @(negedge clk);
    bus.iHighCycles = CW'(2);
    bus.iLowCycles  = CW'(2);
    bus.iNumPulses  = CW'(3);
    bus.iStart = 1'b1;
    bus.iAbort = 1'b1;
    @(negedge clk);
    bus.iStart = 1'b0;
    bus.iAbort = 1'b0;
    idle_e.cnt = last_cnt;
    for (int t = 1; t <= 3; t++) begin
      @(posedge clk);
      #1 chk_all("start_abort", t, idle_e);
    end

    // Asynchronous reset in the middle of a high phase
    @(negedge clk);
    bus.iHighCycles = CW'(5);
    bus.iLowCycles  = CW'(2);
    bus.iNumPulses  = CW'(3);
    bus.iStart = 1'b1;
    @(posedge clk);
    #1 bus.iStart = 1'b0;
    @(posedge clk);
    #1 chk("midrst_pre.hit", 2, 32'(bus.oHit), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    idle_e.cnt = 0;
    chk_all("midrst", 2, idle_e);
    @(negedge clk) rst_n = 1'b1;
    for (int t = 1; t <= 6; t++) begin
      @(posedge clk);
      #1 chk_all("after_rst", t, idle_e);
    end

    // Random trains with occasional aborts and ignored-input noise
    for (int i = 0; i < 20; i++) begin
      h = $urandom_range(0, 4);
      l = $urandom_range(0, 4);
      n = $urandom_range(0, 5);
      per = ((h == 0) ? 1 : h) + ((l == 0) ? 1 : l);
      ta = (n > 0 && $urandom_range(0, 2) == 0) ? $urandom_range(1, n * per) : 0;
      run_train("rand", h, l, n, ta, 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/hit_pulse_gen.md
# hit_pulse_gen

Programmable hit-pulse generator for the TDC front end. It is the transmitting end of the hit path: it produces the `iHit`-style pulse trains that the edge detector consumes. Each train has a configurable high width, low gap and pulse count. It emits rise and fall marker strobes aligned to its own output edges, so a bench or on-chip checker can compare them against the detector's `oRise`/`oFall`. It sits between the control/config logic and the detector input during self-test and calibration.

## Interface
Parameters:
- `CNT_W`, 16, width of the width, gap and count fields and counters.

Ports:
- `iClk`, in, 1, system clock. All logic is on the rising edge.
- `iRst`, in, 1, asynchronous, active-low reset.
- `iStart`, in, 1, start request. Sampled only in IDLE.
- `iHighCycles`, in, `CNT_W`, high width in cycles. 0 is treated as 1.
- `iLowCycles`, in, `CNT_W`, low gap in cycles. 0 is treated as 1.
- `iNumPulses`, in, `CNT_W`, number of pulses in the train.
- `iAbort`, in, 1, terminates the train.
- `oHit`, out, 1, registered pulse output.
- `oRiseMark`, out, 1, one-cycle strobe in the first high cycle of each pulse.
- `oFallMark`, out, 1, one-cycle strobe in the first low cycle after each pulse.
- `oBusy`, out, 1, high in HIGH and LOW.
- `oDone`, out, 1, one-cycle strobe at the end of a train.
- `oPulseCnt`, out, `CNT_W`, number of pulses emitted so far in the current or last train.

## Operation
- FSM states: IDLE, HIGH, LOW, DONE. All outputs are registered.
- **IDLE**, `iStart`=1, `iNumPulses`≠0:
  - latch H=max(`iHighCycles`,1), L=max(`iLowCycles`,1), N=`iNumPulses`;
  - clear `oPulseCnt`; go to HIGH.
- **IDLE**, `iStart`=1, `iNumPulses`=0: clear `oPulseCnt`; go to DONE. No pulse is emitted.
- **HIGH**:
  - `oHit`=1 for exactly H cycles;
  - `oRiseMark`=1 in the first cycle only;
  - `oPulseCnt` increments in that same first cycle;
  - after H cycles, go to LOW.
- **LOW**:
  - `oHit`=0 for exactly L cycles;
  - `oFallMark`=1 in the first cycle only;
  - after L cycles, go to HIGH if `oPulseCnt`<N, else go to DONE.
  - The trailing gap after the last pulse is always emitted.
- **DONE**: `oDone`=1 for one cycle, then return to IDLE.
- Config inputs are ignored outside IDLE. Latched values hold for the whole train.
- `iStart` while not in IDLE is ignored and is not queued.
- **`iAbort`** has priority over all other inputs.
  - In HIGH or LOW: go to DONE next cycle.
  - In HIGH, `oHit` drops next cycle and `oFallMark` pulses with it.
  - `oPulseCnt` keeps the count reached.
  - In IDLE, abort is ignored. If `iAbort` and `iStart` coincide in IDLE, the start is discarded.
- Counters: the phase counter is `CNT_W` wide and counts up to H−1 or L−1. It never wraps because H,L ≤ 2^CNT_W−1. N=2^CNT_W−1 is legal.
- **Reset**, asynchronous, at any time including mid-pulse:
  - state goes to IDLE;
  - `oHit`, `oRiseMark`, `oFallMark`, `oBusy` and `oDone` go to 0;
  - `oPulseCnt` goes to 0.
  - Release is synchronous to the next rising edge.

## Timing
- `iStart` sampled at edge k: `oHit`, `oRiseMark` and `oBusy` are high from edge k+1.
- Period of each pulse = H+L cycles. Train length = N·(H+L) cycles.
- `oDone` is high in the cycle after the last LOW cycle.
- From `oDone`, the earliest next start can be sampled at the following edge. `oHit` then rises 2 cycles after `oDone`.
- Abort sampled at edge a: `oHit`=0 and `oBusy`=0 from a+1. `oDone` is also high at a+1.
- `oRiseMark` and `oFallMark` never assert in the same cycle, except at the abort fall: `oFallMark` only.
- Each `oRiseMark` precedes the matching detector `oRise` by that detector's fixed latency.

## Test plan
- **Reset:** assert `iRst`=0 mid-HIGH with H=5 -> all outputs 0 in the same cycle; IDLE after release; no pulse until a new `iStart`.
- **Basic train:** H=3, L=2, N=4, start at edge 10 -> `oHit` high at cycles 11–13, 16–18, 21–23, 26–28; `oDone` at cycle 31; `oPulseCnt`=4; four rise and four fall marks.
- **Zero handling:**
  - N=0 -> `oDone` one cycle after start, `oHit` never rises;
  - H=0, L=0, N=2 -> pulses behave as H=L=1, giving the pattern 1,0,1,0 then `oDone`.
- **Abort:** H=10, L=10, N=3, `iAbort` in the 4th cycle of pulse 2 -> `oHit` drops next cycle; `oFallMark` and `oDone` pulse; `oPulseCnt`=2.
- **Ignored inputs:** `iStart` and config changes during a train -> no effect on widths or count; no restart after `oDone`.
- **Loopback:** drive `oHit` into the edge detector with H=1, L=1, N=8 -> detector gives 8 `oRise` and 8 `oFall`, each offset from the markers by the detector latency.
